// File: rtl/fpu_entry_controller.sv
// ---------------------------------------------------------------------------
// fpu_entry_controller
//
// Purpose:
//   Sequences one FPU operation from board I/O. Two 32-bit operands are built
//   from the 16-bit switch bank, one half per button press (A high, A low,
//   B high, B low). The block then pulses fpu_start and waits for fpu_done.
//   Finally it steps the 32-bit result out to the 16-bit display, high half
//   first, one half per press.
//
// Optional feature (compile-time macro FPU_TIMEOUT_EN):
//   When defined, a WAIT-state watchdog counts TIMEOUT_CYCLES cycles. If the
//   FPU has not answered by then, NAN_PATTERN is substituted for the result
//   and error is raised. When undefined, WAIT holds until fpu_done, no
//   counter exists and error is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit in clk cycles (2..65535)
//   NAN_PATTERN     result value substituted on timeout
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   btn_pulse   in   one-cycle advance pulse from the button stage
//   sw_data     in   [15:0] switch value captured on btn_pulse
//   fpu_done    in   FPU result valid (level or pulse)
//   fpu_result  in   [31:0] FPU result, valid with fpu_done
//   op_a        out  [31:0] operand A, registered
//   op_b        out  [31:0] operand B, registered
//   fpu_start   out  one-cycle start pulse (high only in START)
//   disp_value  out  [15:0] registered display value
//   state_code  out  [2:0] current state encoding for LEDs
//   error       out  timeout occurred on the last operation
// ---------------------------------------------------------------------------
module fpu_entry_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] NAN_PATTERN    = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_pulse,
  input  logic [15:0] sw_data,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        fpu_start,
  output logic [15:0] disp_value,
  output logic [2:0]  state_code,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_ENTER_A_HI = 3'd0,
    ST_ENTER_A_LO = 3'd1,
    ST_ENTER_B_HI = 3'd2,
    ST_ENTER_B_LO = 3'd3,
    ST_START      = 3'd4,
    ST_WAIT       = 3'd5,
    ST_SHOW_HI    = 3'd6,
    ST_SHOW_LO    = 3'd7
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] result_reg;
  logic        load_result;
  logic        timeout_hit;

`ifdef FPU_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timeout_cnt;
  logic        error_reg;

  // The counter sits at zero outside WAIT, so it reads 0 in the first WAIT
  // cycle. It reaches TIMEOUT_LAST in the TIMEOUT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_cnt <= 16'd0;
    end else if (state != ST_WAIT) begin
      timeout_cnt <= 16'd0;
    end else begin
      timeout_cnt <= timeout_cnt + 16'd1;
    end
  end

  // A done arriving in the final cycle takes priority over the timeout.
  assign timeout_hit = (state == ST_WAIT) && !fpu_done && (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      error_reg <= 1'b0;
    end else if ((state == ST_WAIT) && fpu_done) begin
      error_reg <= 1'b0;
    end else if (timeout_hit) begin
      error_reg <= 1'b1;
    end else if ((state == ST_SHOW_LO) && btn_pulse) begin
      error_reg <= 1'b0;
    end
  end

  assign error = error_reg;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ENTER_A_HI;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode. START always lasts one cycle. A done seen already in
  // START skips WAIT entirely.
  always_comb begin
    next_state  = state;
    load_result = 1'b0;
    case (state)
      ST_ENTER_A_HI: if (btn_pulse) next_state = ST_ENTER_A_LO;
      ST_ENTER_A_LO: if (btn_pulse) next_state = ST_ENTER_B_HI;
      ST_ENTER_B_HI: if (btn_pulse) next_state = ST_ENTER_B_LO;
      ST_ENTER_B_LO: if (btn_pulse) next_state = ST_START;
      ST_START: begin
        if (fpu_done) begin
          load_result = 1'b1;
          next_state  = ST_SHOW_HI;
        end else begin
          next_state  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fpu_done) begin
          load_result = 1'b1;
          next_state  = ST_SHOW_HI;
        end else if (timeout_hit) begin
          next_state  = ST_SHOW_HI;
        end
      end
      ST_SHOW_HI: if (btn_pulse) next_state = ST_SHOW_LO;
      ST_SHOW_LO: if (btn_pulse) next_state = ST_ENTER_A_HI;
      default:    next_state = ST_ENTER_A_HI;
    endcase
  end

  // Operand capture, result latch and display register. Operands only change
  // in the ENTER states. An untouched low half keeps its old value until it
  // is overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      result_reg <= 32'd0;
      disp_value <= 16'd0;
    end else begin
      if (btn_pulse) begin
        case (state)
          ST_ENTER_A_HI: op_a[31:16] <= sw_data;
          ST_ENTER_A_LO: op_a[15:0]  <= sw_data;
          ST_ENTER_B_HI: op_b[31:16] <= sw_data;
          ST_ENTER_B_LO: op_b[15:0]  <= sw_data;
          default: ;
        endcase
      end

      if (load_result) begin
        result_reg <= fpu_result;
      end else if (timeout_hit) begin
        result_reg <= NAN_PATTERN;
      end

      case (state)
        ST_ENTER_A_HI, ST_ENTER_A_LO,
        ST_ENTER_B_HI, ST_ENTER_B_LO: disp_value <= sw_data;
        ST_SHOW_HI:                   disp_value <= result_reg[31:16];
        ST_SHOW_LO:                   disp_value <= result_reg[15:0];
        default:                      disp_value <= 16'h0000;
      endcase
    end
  end

  assign fpu_start  = (state == ST_START);
  assign state_code = state;

endmodule

// File: tb/tb_fpu_entry_controller.sv
// ---------------------------------------------------------------------------
// tb_fpu_entry_controller
//
// Self-checking bench for fpu_entry_controller. Expected FPU results are
// pushed into a queue when fpu_done (or a timeout) is provoked. They are
// popped when the display steps through SHOW_HI / SHOW_LO. Build with
// FPU_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT_CYCLES = 8).
// ---------------------------------------------------------------------------
module tb_fpu_entry_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_pulse;
  logic [15:0] sw_data;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        fpu_start;
  logic [15:0] disp_value;
  logic [2:0]  state_code;
  logic        error;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fpu_entry_controller #(
    .TIMEOUT_CYCLES(8),
    .NAN_PATTERN   (32'h7FC00000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pulse (btn_pulse),
    .sw_data   (sw_data),
    .fpu_done  (fpu_done),
    .fpu_result(fpu_result),
    .op_a      (op_a),
    .op_b      (op_b),
    .fpu_start (fpu_start),
    .disp_value(disp_value),
    .state_code(state_code),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [15:0] d);
    sw_data   = d;
    btn_pulse = 1'b1;
    tick();
    btn_pulse = 1'b0;
  endtask

  task automatic enter_operands(input logic [31:0] a, input logic [31:0] b);
    press(a[31:16]);
    press(a[15:0]);
    press(b[31:16]);
    press(b[15:0]);
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_pulse = 1'b0; sw_data = 16'h0; fpu_done = 1'b0; fpu_result = 32'h0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (state_code !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_code); end
    checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_ops: got %h/%h expected 0/0", op_a, op_b); end
    checks++; if (disp_value !== 16'h0 || fpu_start !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL reset_outs: got disp=%h start=%b err=%b expected 0/0/0", disp_value, fpu_start, error); end
  endtask

  task automatic test_entry();
    logic [15:0] vals [4];
    vals[0] = 16'h3F80; vals[1] = 16'h0000; vals[2] = 16'h4000; vals[3] = 16'h0000;
    sw_data = 16'h3F80;
    tick();
    checks++; if (state_code !== 3'd0 || disp_value !== 16'h3F80) begin errors++; $display("[TB] FAIL entry_echo: got state=%0d disp=%h expected 0/3f80", state_code, disp_value); end
    for (int i = 0; i < 4; i++) begin
      press(vals[i]);
      checks++; if (state_code !== 3'(i + 1)) begin errors++; $display("[TB] FAIL entry_state: got %0d expected %0d", state_code, i + 1); end
      if (i < 3) begin
        checks++; if (fpu_start !== 1'b0) begin errors++; $display("[TB] FAIL entry_start_early: got %b expected 0", fpu_start); end
      end
    end
    checks++; if (fpu_start !== 1'b1) begin errors++; $display("[TB] FAIL start_pulse: got %b expected 1", fpu_start); end
    checks++; if (op_a !== 32'h3F800000 || op_b !== 32'h40000000) begin errors++; $display("[TB] FAIL operands: got %h/%h expected 3f800000/40000000", op_a, op_b); end
    tick();
    checks++; if (state_code !== 3'd5 || fpu_start !== 1'b0) begin errors++; $display("[TB] FAIL wait_entry: got state=%0d start=%b expected 5/0", state_code, fpu_start); end
    checks++; if (disp_value !== 16'h0000) begin errors++; $display("[TB] FAIL wait_disp: got %h expected 0000", disp_value); end
  endtask

  task automatic test_show();
    logic [31:0] exp;
    tick(); tick(); tick();
    fpu_done = 1'b1; fpu_result = 32'h40400000; exp_q.push_back(32'h40400000);
    tick();
    fpu_done = 1'b0; fpu_result = 32'hFFFF_FFFF;
    checks++; if (state_code !== 3'd6) begin errors++; $display("[TB] FAIL show_hi_state: got %0d expected 6", state_code); end
    tick();
    exp = exp_q[0];
    checks++; if (disp_value !== exp[31:16]) begin errors++; $display("[TB] FAIL show_hi_disp: got %h expected %h", disp_value, exp[31:16]); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL show_error: got %b expected 0", error); end
    press(16'h1234);
    checks++; if (state_code !== 3'd7) begin errors++; $display("[TB] FAIL show_lo_state: got %0d expected 7", state_code); end
    tick();
    exp = exp_q.pop_front();
    checks++; if (disp_value !== exp[15:0]) begin errors++; $display("[TB] FAIL show_lo_disp: got %h expected %h", disp_value, exp[15:0]); end
    press(16'h0);
    checks++; if (state_code !== 3'd0) begin errors++; $display("[TB] FAIL show_return: got %0d expected 0", state_code); end
  endtask

  task automatic test_ignored();
    logic [31:0] exp;
    int starts;
    press(16'h1111);
    fpu_done = 1'b1; fpu_result = 32'hDEADBEEF;
    tick();
    fpu_done = 1'b0;
    checks++; if (state_code !== 3'd1) begin errors++; $display("[TB] FAIL ign_done_enter: got %0d expected 1", state_code); end
    press(16'h2222); press(16'h3333); press(16'h4444);
    starts = (fpu_start === 1'b1) ? 1 : 0;
    btn_pulse = 1'b1; sw_data = 16'hABCD;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fpu_start === 1'b1) starts++;
      checks++; if (state_code !== 3'd5) begin errors++; $display("[TB] FAIL ign_btn_wait: got %0d expected 5", state_code); end
    end
    btn_pulse = 1'b0;
    checks++; if (starts !== 1) begin errors++; $display("[TB] FAIL ign_start_count: got %0d expected 1", starts); end
    checks++; if (op_a !== 32'h11112222 || op_b !== 32'h33334444) begin errors++; $display("[TB] FAIL ign_operands: got %h/%h expected 11112222/33334444", op_a, op_b); end
    fpu_done = 1'b1; fpu_result = 32'h12345678; exp_q.push_back(32'h12345678);
    tick();
    fpu_result = 32'hFFFFFFFF;
    tick();
    fpu_done = 1'b0;
    exp = exp_q[0];
    checks++; if (state_code !== 3'd6 || disp_value !== exp[31:16]) begin errors++; $display("[TB] FAIL ign_done_show: got state=%0d disp=%h expected 6/%h", state_code, disp_value, exp[31:16]); end
    press(16'h0); tick();
    exp = exp_q.pop_front();
    checks++; if (disp_value !== exp[15:0]) begin errors++; $display("[TB] FAIL ign_show_lo: got %h expected %h", disp_value, exp[15:0]); end
    press(16'h0);
  endtask

  task automatic test_done_in_start();
    logic [31:0] exp;
    press(16'h4000);
    checks++; if (op_a !== 32'h40002222) begin errors++; $display("[TB] FAIL low_half_persist: got %h expected 40002222", op_a); end
    press(16'h0000); press(16'h3F80); press(16'h0000);
    checks++; if (state_code !== 3'd4) begin errors++; $display("[TB] FAIL dis_start: got %0d expected 4", state_code); end
    fpu_done = 1'b1; fpu_result = 32'hC0000000; exp_q.push_back(32'hC0000000);
    tick();
    fpu_done = 1'b0;
    checks++; if (state_code !== 3'd6) begin errors++; $display("[TB] FAIL dis_skip_wait: got %0d expected 6", state_code); end
    tick();
    exp = exp_q[0];
    checks++; if (disp_value !== exp[31:16]) begin errors++; $display("[TB] FAIL dis_hi: got %h expected %h", disp_value, exp[31:16]); end
    press(16'h0); tick();
    exp = exp_q.pop_front();
    checks++; if (disp_value !== exp[15:0]) begin errors++; $display("[TB] FAIL dis_lo: got %h expected %h", disp_value, exp[15:0]); end
    press(16'h0);
  endtask

  task automatic test_timeout();
    logic [31:0] exp;
    enter_operands(32'h3F800000, 32'h3F800000);
    tick();
`ifdef FPU_TIMEOUT_EN
    exp_q.push_back(32'h7FC00000);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (state_code !== 3'd5) begin errors++; $display("[TB] FAIL to_hold: got %0d expected 5 at wait cycle %0d", state_code, i + 2); end
    end
    tick();
    checks++; if (state_code !== 3'd6 || error !== 1'b1) begin errors++; $display("[TB] FAIL to_fire: got state=%0d err=%b expected 6/1", state_code, error); end
    tick();
    exp = exp_q[0];
    checks++; if (disp_value !== exp[31:16]) begin errors++; $display("[TB] FAIL to_disp_hi: got %h expected %h", disp_value, exp[31:16]); end
    press(16'h0); tick();
    exp = exp_q.pop_front();
    checks++; if (disp_value !== exp[15:0] || error !== 1'b1) begin errors++; $display("[TB] FAIL to_disp_lo: got %h err=%b expected %h/1", disp_value, error, exp[15:0]); end
    press(16'h0);
    checks++; if (state_code !== 3'd0 || error !== 1'b0) begin errors++; $display("[TB] FAIL to_clear: got state=%0d err=%b expected 0/0", state_code, error); end
    enter_operands(32'h40000000, 32'h40000000);
    tick();
    for (int i = 0; i < 7; i++) tick();
    fpu_done = 1'b1; fpu_result = 32'h41200000; exp_q.push_back(32'h41200000);
    tick();
    fpu_done = 1'b0;
    checks++; if (state_code !== 3'd6 || error !== 1'b0) begin errors++; $display("[TB] FAIL to_done_wins: got state=%0d err=%b expected 6/0", state_code, error); end
`else
    for (int i = 0; i < 20; i++) tick();
    checks++; if (state_code !== 3'd5 || error !== 1'b0) begin errors++; $display("[TB] FAIL wait_forever: got state=%0d err=%b expected 5/0", state_code, error); end
    fpu_done = 1'b1; fpu_result = 32'h41200000; exp_q.push_back(32'h41200000);
    tick();
    fpu_done = 1'b0;
`endif
    tick();
    exp = exp_q[0];
    checks++; if (disp_value !== exp[31:16]) begin errors++; $display("[TB] FAIL late_done_hi: got %h expected %h", disp_value, exp[31:16]); end
    press(16'h0); tick();
    exp = exp_q.pop_front();
    checks++; if (disp_value !== exp[15:0]) begin errors++; $display("[TB] FAIL late_done_lo: got %h expected %h", disp_value, exp[15:0]); end
    press(16'h0);
  endtask

  task automatic test_reset_mid();
    enter_operands(32'h12345678, 32'h9ABCDEF0);
    tick(); tick();
    reset = 1'b1; fpu_done = 1'b1; fpu_result = 32'h55555555;
    tick();
    reset = 1'b0;
    checks++; if (state_code !== 3'd0 || op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("[TB] FAIL rst_wait_regs: got state=%0d a=%h b=%h expected 0/0/0", state_code, op_a, op_b); end
    checks++; if (disp_value !== 16'h0 || fpu_start !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_outs: got disp=%h start=%b err=%b expected 0/0/0", disp_value, fpu_start, error); end
    tick();
    fpu_done = 1'b0;
    checks++; if (state_code !== 3'd0) begin errors++; $display("[TB] FAIL rst_pending_done: got %0d expected 0", state_code); end
    press(16'hAAAA); press(16'hBBBB); press(16'hCCCC);
    sw_data = 16'hDDDD;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (state_code !== 3'd0 || op_a !== 32'h0 || op_b !== 32'h0 || disp_value !== 16'h0) begin errors++; $display("[TB] FAIL rst_enter: got state=%0d a=%h b=%h disp=%h expected 0/0/0/0", state_code, op_a, op_b, disp_value); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    test_reset();
    test_entry();
    test_show();
    test_ignored();
    test_done_in_start();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
